// File: rtl/sdram_req_arbiter.sv
// Arbitrates CPU, loader and tape requests onto a single-outstanding SDRAM controller port.
// Fixed priority CPU > loader > tape, with a starvation override for tape and a WAIT timeout.
module sdram_req_arbiter #(
    parameter int unsigned TIMEOUT      = 31,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,

    input  logic [22:0] ldr_addr,
    input  logic [7:0]  ldr_din,
    input  logic        ldr_wr,
    output logic        ldr_busy,
    output logic        ldr_ovf,

    input  logic [22:0] tape_addr,
    input  logic [7:0]  tape_din,
    input  logic        tape_rd,
    input  logic        tape_wr,
    output logic [7:0]  tape_dout,
    output logic        tape_ack,

    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_dout,
    input  logic        mem_done,

    output logic        err_timeout
);

    localparam int unsigned TimerW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_t;

    typedef enum logic [1:0] {
        SrcCpu,
        SrcLdr,
        SrcTape
    } src_t;

    state_t state;
    src_t   gsrc;
    src_t   gnext;

    logic [TimerW-1:0]  timer;
    logic [StarveW-1:0] starve;

    // CPU request capture
    logic        cpu_rd_q;
    logic        cpu_wr_q;
    logic        cpu_pend;
    logic        cpu_req_wr;
    logic [22:0] cpu_req_addr;
    logic [7:0]  cpu_req_din;

    // Loader one-deep buffer
    logic [22:0] ldr_req_addr;
    logic [7:0]  ldr_req_din;

    // Tape request capture
    logic        tape_pend;
    logic        tape_arm;
    logic        tape_req_wr;
    logic [22:0] tape_req_addr;
    logic [7:0]  tape_req_din;

    logic        cpu_rd_rise;
    logic        cpu_wr_rise;
    logic        cpu_cap;
    logic        ldr_cap;
    logic        ldr_drop;
    logic        tape_cap;
    logic        any_pend;
    logic        force_tape;
    logic        timer_hit;
    logic        finish;
    logic [7:0]  rdata;

    logic [22:0] next_addr;
    logic [7:0]  next_din;
    logic        next_wr;

    assign cpu_rd_rise = cpu_rd & ~cpu_rd_q;
    assign cpu_wr_rise = cpu_wr & ~cpu_wr_q;
    assign cpu_cap     = (cpu_rd_rise | cpu_wr_rise) & ~cpu_pend;
    assign ldr_cap     = ldr_wr & ~ldr_busy;
    assign ldr_drop    = ldr_wr & ldr_busy;
    assign tape_cap    = (tape_rd | tape_wr) & tape_arm & ~tape_pend;

    assign any_pend   = cpu_pend | ldr_busy | tape_pend;
    assign force_tape = tape_pend && (starve == StarveW'(STARVE_LIMIT));

    assign timer_hit = (timer == TimerW'(TIMEOUT - 1));
    // A done coinciding with the timeout wins, so the real data is kept
    assign finish    = (state == StWait) && (mem_done || timer_hit);
    assign rdata     = mem_done ? mem_dout : 8'hFF;

    assign cpu_wait = cpu_pend;

    always_comb begin
        gnext = SrcTape;
        if (force_tape) begin
            gnext = SrcTape;
        end else if (cpu_pend) begin
            gnext = SrcCpu;
        end else if (ldr_busy) begin
            gnext = SrcLdr;
        end else begin
            gnext = SrcTape;
        end
    end

    always_comb begin
        next_addr = tape_req_addr;
        next_din  = tape_req_din;
        next_wr   = tape_req_wr;
        case (gnext)
            SrcCpu: begin
                next_addr = cpu_req_addr;
                next_din  = cpu_req_din;
                next_wr   = cpu_req_wr;
            end
            SrcLdr: begin
                next_addr = ldr_req_addr;
                next_din  = ldr_req_din;
                next_wr   = 1'b1;
            end
            default: begin
                next_addr = tape_req_addr;
                next_din  = tape_req_din;
                next_wr   = tape_req_wr;
            end
        endcase
    end

    // Request capture: runs in every FSM state so requests queue up during a transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rd_q      <= 1'b0;
            cpu_wr_q      <= 1'b0;
            cpu_pend      <= 1'b0;
            cpu_req_wr    <= 1'b0;
            cpu_req_addr  <= '0;
            cpu_req_din   <= '0;
            ldr_busy      <= 1'b0;
            ldr_ovf       <= 1'b0;
            ldr_req_addr  <= '0;
            ldr_req_din   <= '0;
            tape_pend     <= 1'b0;
            tape_arm      <= 1'b1;
            tape_req_wr   <= 1'b0;
            tape_req_addr <= '0;
            tape_req_din  <= '0;
        end else begin
            cpu_rd_q <= cpu_rd;
            cpu_wr_q <= cpu_wr;

            if (cpu_cap) begin
                cpu_pend     <= 1'b1;
                cpu_req_wr   <= cpu_wr_rise;
                cpu_req_addr <= cpu_addr;
                cpu_req_din  <= cpu_din;
            end else if (finish && gsrc == SrcCpu) begin
                cpu_pend <= 1'b0;
            end

            if (ldr_cap) begin
                ldr_busy     <= 1'b1;
                ldr_req_addr <= ldr_addr;
                ldr_req_din  <= ldr_din;
            end else if (finish && gsrc == SrcLdr) begin
                ldr_busy <= 1'b0;
            end
            if (ldr_drop) begin
                ldr_ovf <= 1'b1;
            end

            if (tape_cap) begin
                tape_pend     <= 1'b1;
                tape_arm      <= 1'b0;
                tape_req_wr   <= tape_wr;
                tape_req_addr <= tape_addr;
                tape_req_din  <= tape_din;
            end else begin
                if (finish && gsrc == SrcTape) begin
                    tape_pend <= 1'b0;
                end
                // Level-sensitive tape requests must go idle before another is accepted
                if (!tape_rd && !tape_wr && !tape_pend) begin
                    tape_arm <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            gsrc        <= SrcCpu;
            timer       <= '0;
            starve      <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_dout    <= 8'hFF;
            tape_dout   <= 8'hFF;
            tape_ack    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                StIdle: begin
                    if (any_pend) begin
                        state    <= StIssue;
                        gsrc     <= gnext;
                        mem_addr <= next_addr;
                        mem_din  <= next_din;
                        mem_rd   <= ~next_wr;
                        mem_wr   <= next_wr;
                        if (gnext == SrcTape) begin
                            starve <= '0;
                        end else if (tape_pend && starve != StarveW'(STARVE_LIMIT)) begin
                            starve <= starve + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state <= StWait;
                    timer <= '0;
                end
                StWait: begin
                    if (finish) begin
                        state <= StIdle;
                        if (!mem_done) begin
                            err_timeout <= 1'b1;
                        end
                        case (gsrc)
                            SrcCpu: begin
                                if (!cpu_req_wr) begin
                                    cpu_dout <= rdata;
                                end
                            end
                            SrcTape: begin
                                if (!tape_req_wr) begin
                                    tape_dout <= rdata;
                                end
                                tape_ack <= ~tape_ack;
                            end
                            default: ;
                        endcase
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/sdram_req_arbiter.md
SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset; both are listed first below.
REQ-002 Parameter TIMEOUT, default 31: WAIT cycles allowed before a transaction is aborted.
REQ-003 Parameter STARVE_LIMIT, default 4: number of non-tape grants allowed while tape is pending before tape is forced first.
REQ-004 The block SHALL have the following ports (name  direction  width  meaning):
 clk  in  1  system clock
 reset  in  1  synchronous active-high reset
 cpu_addr  in  23  CPU byte address
 cpu_din  in  8  CPU write data
 cpu_rd  in  1  CPU read level; rising edge requests
 cpu_wr  in  1  CPU write level; rising edge requests
 cpu_dout  out  8  CPU read data
 cpu_wait  out  1  CPU transaction pending
 ldr_addr  in  23  loader byte address
 ldr_din  in  8  loader data
 ldr_wr  in  1  loader write strobe, 1 cycle
 ldr_busy  out  1  loader buffer full
 ldr_ovf  out  1  sticky: strobe dropped
 tape_addr  in  23  tape byte address
 tape_din  in  8  tape write data
 tape_rd  in  1  tape read level
 tape_wr  in  1  tape write level
 tape_dout  out  8  tape read data
 tape_ack  out  1  toggles per completed tape transaction
 mem_addr  out  23  address to SDRAM controller
 mem_din  out  8  write data to controller
 mem_rd  out  1  read strobe, 1 cycle
 mem_wr  out  1  write strobe, 1 cycle
 mem_dout  in  8  read data from controller
 mem_done  in  1  completion pulse, 1 cycle
 err_timeout  out  1  sticky: a transaction timed out

Function
REQ-005 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-006 CPU request capture: a rising edge of cpu_rd or cpu_wr, sampled against the previous-cycle register, SHALL set cpu_pend and latch the address, data and direction; cpu_wr wins if both rise together; edges while cpu_pend=1 SHALL be ignored.
REQ-007 cpu_wait SHALL equal cpu_pend, as a registered output.
REQ-008 Loader: ldr_wr with ldr_busy=0 SHALL latch address and data into a 1-deep buffer and set ldr_busy.
REQ-009 Loader: ldr_wr with ldr_busy=1 SHALL be dropped and SHALL set ldr_ovf until reset.
REQ-010 Tape: tape_rd or tape_wr high, while tape_arm=1 and no tape transaction is pending, SHALL set tape_pend and latch the request (tape_wr wins), then clear tape_arm.
REQ-011 tape_arm SHALL be set again after tape_rd and tape_wr are both low for at least 1 cycle with tape_pend=0.
REQ-012 In IDLE, the arbiter SHALL use fixed priority CPU > loader > tape.
REQ-013 Exception: when tape_pend=1 and the starve counter equals STARVE_LIMIT, tape SHALL be granted first.
REQ-014 The starve counter SHALL increment on each CPU or loader grant while tape_pend=1, saturating at STARVE_LIMIT, and SHALL clear on a tape grant.
REQ-015 IDLE with any pending request SHALL go to ISSUE, registering mem_addr, mem_din and exactly one of mem_rd/mem_wr.
REQ-016 The strobe SHALL be high only during the ISSUE cycle; the next state is WAIT with the timer cleared.
REQ-017 Latency: cpu_rd rising at cycle N SHALL give cpu_wait=1 at N+1 and mem_rd=1 at N+2, when the arbiter is idle.
REQ-018 In WAIT, mem_done SHALL load mem_dout into the granted requester's dout (reads only), clear its pend (loader: clear ldr_busy), toggle tape_ack for tape, and return to IDLE.
REQ-019 Back-to-back: a grant SHALL be possible in the IDLE cycle immediately after WAIT, so the next strobe occurs 2 cycles after mem_done.
REQ-020 The WAIT timer SHALL increment each cycle; when it reaches TIMEOUT without mem_done, the transaction SHALL complete as in REQ-018 with read data 8'hFF, and err_timeout SHALL be set.
REQ-021 mem_done on the same cycle as the timeout SHALL be treated as a normal completion, with no error.
REQ-022 mem_done in IDLE or ISSUE SHALL be ignored.
REQ-023 New requests arriving during ISSUE or WAIT SHALL be captured per REQ-006/008/010 and arbitrated at the next IDLE.

Reset
REQ-024 On reset: state=IDLE, mem_rd=mem_wr=0, mem_addr=0, mem_din=0, cpu_dout=tape_dout=8'hFF, tape_ack=0, cpu_wait=ldr_busy=ldr_ovf=err_timeout=0, all pend flags and the starve counter =0, tape_arm=1, edge registers=0.
REQ-025 Reset mid-transaction SHALL abort the transaction with no further strobe; a mem_done arriving after reset SHALL be ignored.

Verification
REQ-026 cpu_rd rises at cycle 10, addr 0x00123, mem_done at 15 with mem_dout 0x5A -> mem_rd=1 only at cycle 12, mem_addr=0x00123, cpu_dout=0x5A and cpu_wait=0 at cycle 16.
REQ-027 cpu_wr edge and ldr_wr strobe in the same cycle -> CPU write issued first; loader issued 2 cycles after the CPU's mem_done; ldr_busy clears after its own done.
REQ-028 tape_rd held high while the CPU issues 5 successive requests -> tape granted after the 4th CPU grant; tape_ack toggles 0->1; no second tape grant until tape_rd has dropped.
REQ-029 ldr_wr strobed twice, 2 cycles apart, with no mem_done -> second strobe dropped, ldr_ovf=1, only one mem_wr.
REQ-030 CPU read with mem_done never asserted -> completion after 31 WAIT cycles, cpu_dout=0xFF, err_timeout=1; mem_done arriving later is ignored.
REQ-031 reset asserted during WAIT -> all outputs at REQ-024 values next cycle; no mem strobe until a new request arrives.
